slice_dyn: RTL

//  Runtime-programmable multi-channel bit slicer. Each of NUM_CHANNELS input words

---
 rtl/slice_dyn.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/slice_dyn.sv
// rtl/slice_dyn.sv - runtime-programmable multi-channel bit slicer
//
// Purpose:
//   Takes NUM_CHANNELS input words per beat. For each channel it extracts an
//   OUTPUT_WIDTH-bit field at that channel's active offset. Offsets are written
//   into shadow registers through the cfg port. A sync pulse copies all of them
//   into the active set at once. Sliced beats go into a 2-entry output FIFO.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   cfg_we        write cfg_offset into shadow[cfg_chan]
//   cfg_chan      channel select for the cfg write
//   cfg_offset    slice offset for that channel
//   sync          commit every shadow offset into the active set
//   cfg_err       sticky flag, set by a dropped (out-of-range) cfg write
//   in_valid      input beat valid
//   in_ready      input beat accepted when in_valid & in_ready (registered)
//   in_data       NUM_CHANNELS input words, ch0 in the LSBs
//   out_valid     output beat valid
//   out_ready     downstream accepts when out_valid & out_ready
//   out_data      NUM_CHANNELS sliced fields, ch0 in the LSBs
module slice_dyn #(
  parameter int INPUT_DATA_WIDTH  = 32,
  parameter int OUTPUT_WIDTH      = 8,
  parameter int NUM_CHANNELS      = 4,
  parameter int OFFSET_REL_TO_MSB = 1,
  localparam int CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int OFF_W  = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     cfg_we,
  input  logic [CHAN_W-1:0]                        cfg_chan,
  input  logic [OFF_W-1:0]                         cfg_offset,
  input  logic                                     sync,
  output logic                                     cfg_err,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [NUM_CHANNELS*INPUT_DATA_WIDTH-1:0] in_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [NUM_CHANNELS*OUTPUT_WIDTH-1:0]     out_data
);

  localparam int OUT_BUS = NUM_CHANNELS * OUTPUT_WIDTH;
  localparam int MAX_OFF = INPUT_DATA_WIDTH - OUTPUT_WIDTH;

  logic [OFF_W-1:0]   shadow_q [NUM_CHANNELS];
  logic [OFF_W-1:0]   shadow_d [NUM_CHANNELS];
  logic [OFF_W-1:0]   active_q [NUM_CHANNELS];
  logic [OFF_W-1:0]   active_d [NUM_CHANNELS];
  logic               cfg_err_q, cfg_err_d;

  logic [OUT_BUS-1:0] mem_q [2];
  logic [OUT_BUS-1:0] mem_d [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_BUS-1:0] out_data_q, out_data_d;

  logic               cfg_bad;
  logic               push, pop;
  logic [OUT_BUS-1:0] slice_data;

  // Configuration: shadow write, atomic commit, sticky error
  always_comb begin
    cfg_bad   = cfg_we && ((int'(cfg_chan) >= NUM_CHANNELS) || (int'(cfg_offset) > MAX_OFF));
    cfg_err_d = cfg_err_q | cfg_bad;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      shadow_d[c] = shadow_q[c];
      if (cfg_we && !cfg_bad && (int'(cfg_chan) == c)) begin
        shadow_d[c] = cfg_offset;
      end
      // Commit the post-write shadow so a write in the sync cycle is included
      active_d[c] = sync ? shadow_d[c] : active_q[c];
    end
  end

  // Slicing always uses the currently active offsets, so a beat accepted in
  // the sync cycle still sees the old set.
  always_comb begin
    slice_data = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      logic [INPUT_DATA_WIDTH-1:0] word;
      logic [INPUT_DATA_WIDTH-1:0] shifted;
      logic [OFF_W-1:0]            lsb;
      word = in_data[c*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
      // MSB-relative offset o selects bits [W-1-o -: OUT], whose LSB is W-OUT-o
      if (OFFSET_REL_TO_MSB != 0) begin
        lsb = OFF_W'(MAX_OFF) - active_q[c];
      end else begin
        lsb = active_q[c];
      end
      shifted = word >> lsb;
      slice_data[c*OUTPUT_WIDTH +: OUTPUT_WIDTH] = shifted[OUTPUT_WIDTH-1:0];
    end
  end

  // Output FIFO, 2 entries
  always_comb begin
    push     = in_valid && in_ready_q;
    pop      = out_valid_q && out_ready;
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    if (push) begin
      mem_d[wr_ptr_q] = slice_data;
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    in_ready_d  = (count_d < 2'd2);
    out_valid_d = (count_d != 2'd0);
    // Head is held while nothing is buffered; it only changes on push/pop
    out_data_d  = out_valid_d ? mem_d[rd_ptr_d] : out_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        shadow_q[c] <= '0;
        active_q[c] <= '0;
      end
      cfg_err_q   <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        shadow_q[c] <= shadow_d[c];
        active_q[c] <= active_d[c];
      end
      cfg_err_q   <= cfg_err_d;
      mem_q[0]    <= mem_d[0];
      mem_q[1]    <= mem_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign cfg_err   = cfg_err_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
